// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage behind the load/store buffer.
// Takes one load or store at a time and requests the shared byte-wide memory
// port from the memory controller. It then moves 1/2/4 bytes serially in
// little-endian order. A load returns a sign- or zero-extended word to the LSB
// and broadcasts it on the CDB. A store only signals completion.
//
// Ports:
//   clk_in, rst_n_in          clock, async active-low reset
//   rdy_in                    global ready; low freezes all state
//   *_from_lsb                request (pulse), direction, op, address, data, ROB id
//   busy_to_lsb/end_to_lsb    busy level, one-cycle completion pulse
//   data_to_lsb               extended load result (held between loads)
//   cdb_*                     load result broadcast
//   roll_back_flag_from_rob   flush of speculative loads
//   req/grant, mem_*          byte-wide memory port toward memctrl
//   io_buffer_full_in         IO write back-pressure
//
// Optional build macro LSU_IO_STALL_EN: store bytes that target the IO window
// while io_buffer_full_in is high are held and retried the next cycle.
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ROB_W  = 4,
   parameter int OP_W   = 6,
   parameter logic [OP_W-1:0] OP_LB  = 1,
   parameter logic [OP_W-1:0] OP_LH  = 2,
   parameter logic [OP_W-1:0] OP_LW  = 3,
   parameter logic [OP_W-1:0] OP_LBU = 4,
   parameter logic [OP_W-1:0] OP_LHU = 5,
   parameter logic [OP_W-1:0] OP_SB  = 6,
   parameter logic [OP_W-1:0] OP_SH  = 7,
   parameter logic [OP_W-1:0] OP_SW  = 8,
   parameter logic [31:0] IO_BASE = 32'h30000
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              rdy_in,
   input  logic              enable_from_lsb,
   input  logic              read_write_flag_from_lsb,
   input  logic [OP_W-1:0]   op_enum_from_lsb,
   input  logic [ADDR_W-1:0] address_from_lsb,
   input  logic [DATA_W-1:0] data_from_lsb,
   input  logic [ROB_W-1:0]  rob_id_from_lsb,
   output logic              busy_to_lsb,
   output logic              end_to_lsb,
   output logic [DATA_W-1:0] data_to_lsb,
   output logic              cdb_enable_out,
   output logic [ROB_W-1:0]  cdb_rob_id_out,
   output logic [DATA_W-1:0] cdb_result_out,
   input  logic              roll_back_flag_from_rob,
   output logic              req_to_memctrl,
   input  logic              grant_from_memctrl,
   output logic [ADDR_W-1:0] mem_a_out,
   output logic              mem_wr_out,
   output logic [7:0]        mem_dout_out,
   input  logic [7:0]        mem_din_in,
   input  logic              io_buffer_full_in
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_XFER  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q;
   logic [OP_W-1:0]   op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] sdata_q;
   logic [ROB_W-1:0]  rob_q;
   logic              wr_q;     // 1 = store
   logic [2:0]        k_q;      // byte index
   logic [2:0]        n_q;      // bytes in this access
   logic [DATA_W-1:0] asm_q;    // load assembly register
   logic              rb_q;     // load was rolled back while in flight
   logic [DATA_W-1:0] res_q;    // last delivered load result

   logic [2:0]        n_in;
   logic [2:0]        kprev;
   logic [ADDR_W-1:0] cur_a;
   logic              io_win;
   logic              stall;
   logic              accept;
   logic [DATA_W-1:0] ext;

   always_comb begin
      n_in = 3'd4;
      case (op_enum_from_lsb)
         OP_LB, OP_LBU, OP_SB: n_in = 3'd1;
         OP_LH, OP_LHU, OP_SH: n_in = 3'd2;
         OP_LW, OP_SW:         n_in = 3'd4;
         default:              n_in = 3'd4;
      endcase
   end

   always_comb begin
      ext = asm_q;
      case (op_q)
         OP_LB:   ext = {{(DATA_W-8){asm_q[7]}}, asm_q[7:0]};
         OP_LH:   ext = {{(DATA_W-16){asm_q[15]}}, asm_q[15:0]};
         OP_LBU:  ext = {{(DATA_W-8){1'b0}}, asm_q[7:0]};
         OP_LHU:  ext = {{(DATA_W-16){1'b0}}, asm_q[15:0]};
         OP_LW:   ext = asm_q;
         default: ext = asm_q;
      endcase
   end

   assign kprev  = k_q - 3'd1;
   assign cur_a  = addr_q + ADDR_W'(k_q);
   assign io_win = (cur_a[17:16] == IO_BASE[17:16]);

`ifdef LSU_IO_STALL_EN
   assign stall = wr_q && io_win && io_buffer_full_in;
`else
   logic unused_io;
   assign unused_io = io_win ^ io_buffer_full_in;
   assign stall     = 1'b0;
`endif

   // A load arriving together with a rollback is already flushed; drop it.
   assign accept = enable_from_lsb && (state_q == S_IDLE) &&
                   !(roll_back_flag_from_rob && !read_write_flag_from_lsb);

   assign busy_to_lsb    = (state_q != S_IDLE);
   assign req_to_memctrl = (state_q == S_WAIT) || (state_q == S_XFER) || (state_q == S_DRAIN);
   assign end_to_lsb     = (state_q == S_DONE);
   assign cdb_enable_out = (state_q == S_DONE) && !wr_q && !rb_q && !roll_back_flag_from_rob;
   assign data_to_lsb    = cdb_enable_out ? ext : res_q;
   assign cdb_result_out = data_to_lsb;
   assign cdb_rob_id_out = rob_q;
   assign mem_a_out      = (state_q == S_XFER) ? cur_a : '0;
   assign mem_wr_out     = (state_q == S_XFER) && wr_q && !stall;
   assign mem_dout_out   = ((state_q == S_XFER) && wr_q) ? sdata_q[8*k_q[1:0] +: 8] : 8'h00;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         sdata_q <= '0;
         rob_q   <= '0;
         wr_q    <= 1'b0;
         k_q     <= '0;
         n_q     <= '0;
         asm_q   <= '0;
         rb_q    <= 1'b0;
         res_q   <= '0;
      end else if (rdy_in) begin
         case (state_q)
            S_IDLE: if (accept) begin
               op_q    <= op_enum_from_lsb;
               addr_q  <= address_from_lsb;
               sdata_q <= data_from_lsb;
               rob_q   <= rob_id_from_lsb;
               wr_q    <= read_write_flag_from_lsb;
               n_q     <= n_in;
               k_q     <= '0;
               asm_q   <= '0;
               rb_q    <= 1'b0;
               state_q <= S_WAIT;
            end
            S_WAIT: if (grant_from_memctrl) begin
               k_q     <= '0;
               state_q <= S_XFER;
            end
            S_XFER: begin
               // Read data trails its address by one cycle.
               if (!wr_q && k_q != 3'd0) asm_q[8*kprev[1:0] +: 8] <= mem_din_in;
               if (!stall) begin
                  k_q <= k_q + 3'd1;
                  if (k_q + 3'd1 == n_q) state_q <= wr_q ? S_DONE : S_DRAIN;
               end
            end
            S_DRAIN: begin
               asm_q[8*kprev[1:0] +: 8] <= mem_din_in;
               state_q <= S_DONE;
            end
            S_DONE: begin
               res_q   <= data_to_lsb;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
         if (state_q != S_IDLE && state_q != S_DONE && roll_back_flag_from_rob && !wr_q)
            rb_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
   localparam int LB = 1, LH = 2, LW = 3, LBU = 4, LHU = 5, SB = 6, SH = 7, SW = 8;
`ifdef LSU_IO_STALL_EN
   localparam bit STALL_ON = 1'b1;
`else
   localparam bit STALL_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdy = 1'b1;
   logic        en = 1'b0, rw = 1'b0;
   logic [5:0]  op = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  rob = '0;
   logic        busy, endp, cdb_en, req, grant = 1'b0, mem_wr, roll = 1'b0, io_full = 1'b0;
   logic [31:0] data_o, cdb_res, mem_a;
   logic [3:0]  cdb_rob;
   logic [7:0]  dout, din = '0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
      .enable_from_lsb(en), .read_write_flag_from_lsb(rw), .op_enum_from_lsb(op),
      .address_from_lsb(addr), .data_from_lsb(wdata), .rob_id_from_lsb(rob),
      .busy_to_lsb(busy), .end_to_lsb(endp), .data_to_lsb(data_o),
      .cdb_enable_out(cdb_en), .cdb_rob_id_out(cdb_rob), .cdb_result_out(cdb_res),
      .roll_back_flag_from_rob(roll), .req_to_memctrl(req), .grant_from_memctrl(grant),
      .mem_a_out(mem_a), .mem_wr_out(mem_wr), .mem_dout_out(dout), .mem_din_in(din),
      .io_buffer_full_in(io_full));

   // Byte memory behind the port (low 16 address bits).
   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_wr) mem[mem_a[15:0]] <= dout;
      else        din <= mem[mem_a[15:0]];
   end

   int checks = 0, errors = 0;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs for the current cycle, set by the stimulus.
   logic        chk_en = 1'b0;
   logic        e_busy = 0, e_end = 0, e_cdb = 0, e_req = 0, e_wr = 0;
   logic [31:0] e_a = 0, e_data = 0;
   logic [7:0]  e_dout = 0;
   logic [3:0]  e_rob = 0;

   always @(negedge clk) if (chk_en) begin
      check("busy", busy, e_busy);
      check("end", endp, e_end);
      check("cdb_en", cdb_en, e_cdb);
      check("req", req, e_req);
      check("mem_wr", mem_wr, e_wr);
      check("mem_a", mem_a, e_a);
      check("mem_dout", dout, e_dout);
      check("data_to_lsb", data_o, e_data);
      if (e_cdb) begin
         check("cdb_rob", cdb_rob, e_rob);
         check("cdb_result", cdb_res, e_data);
      end
   end

   function automatic int nbytes(input int o);
      if (o == LB || o == LBU || o == SB) return 1;
      if (o == LH || o == LHU || o == SH) return 2;
      return 4;
   endfunction

   task automatic set_idle();
      e_busy = 0; e_end = 0; e_cdb = 0; e_req = 0; e_wr = 0; e_a = 0; e_dout = 0;
   endtask

   // One transaction. gdly: cycles before grant; rb_at: XFER cycle of a
   // rollback pulse (-1 none); io_cyc: cycles io_buffer_full is held high.
   task automatic run_op(input int o, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] id, input int gdly, input int rb_at, input int io_cyc);
      int n, k, x, sl;
      bit st, stalled;
      logic [31:0] acc;
      n  = nbytes(o);
      st = (o >= SB);
      acc = 0;
      for (int i = 0; i < n; i++) acc = acc | (32'(mem[16'(a + 32'(i))]) << (8*i));
      if (o == LB && acc >= 128)   acc = acc - 256;
      if (o == LH && acc >= 32768) acc = acc - 65536;
      @(posedge clk); #1;
      en = 1; rw = st; op = 6'(o); addr = a; wdata = d; rob = id;
      set_idle();
      @(posedge clk); #1;
      en = 0; e_busy = 1; e_req = 1;
      for (int c = 0; c < gdly; c++) begin grant = 0; @(posedge clk); #1; end
      grant = 1;
      k = 0; x = 0; sl = io_cyc;
      while (k < n) begin
         @(posedge clk); #1;
         roll    = (x == rb_at);
         io_full = (sl > 0);
         e_a     = a + 32'(k);
         e_dout  = st ? 8'((d >> (8*k)) & 32'hff) : 8'h00;
         stalled = STALL_ON && st && (e_a[17:16] == 2'b11) && (sl > 0);
         e_wr    = st && !stalled;
         if (!stalled) k++;
         if (sl > 0) sl--;
         x++;
      end
      if (!st) begin
         @(posedge clk); #1;
         roll = 0; e_a = 0; e_wr = 0; e_dout = 0;
      end
      @(posedge clk); #1;
      roll = 0; io_full = 0;
      e_req = 0; e_end = 1; e_a = 0; e_wr = 0; e_dout = 0;
      e_cdb = !st && (rb_at < 0);
      if (e_cdb) begin e_data = acc; e_rob = id; end
      @(posedge clk); #1;
      grant = 0;
      set_idle();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h100] = 8'h11; mem[16'h101] = 8'h22; mem[16'h102] = 8'h33; mem[16'h103] = 8'h44;
      mem[16'h200] = 8'h80;
      mem[16'h300] = 8'h01; mem[16'h301] = 8'h80;
      mem[16'h400] = 8'hAA; mem[16'h401] = 8'hBB; mem[16'h402] = 8'hCC; mem[16'h403] = 8'hDD;

      #2;
      check("rst_busy", busy, 0);   check("rst_end", endp, 0);
      check("rst_cdb", cdb_en, 0);  check("rst_req", req, 0);
      check("rst_wr", mem_wr, 0);   check("rst_a", mem_a, 0);
      check("rst_dout", dout, 0);   check("rst_data", data_o, 0);
      check("rst_rob", cdb_rob, 0); check("rst_res", cdb_res, 0);
      @(posedge clk); #1; rst_n = 1;
      chk_en = 1;

      run_op(LW, 32'h100, 0, 4'd5, 0, -1, 0);
      check("lw_lit", data_o, 32'h44332211);
      run_op(LB, 32'h200, 0, 4'd1, 2, -1, 0);
      check("lb_lit", data_o, 32'hFFFFFF80);
      run_op(LBU, 32'h200, 0, 4'd2, 0, -1, 0);
      check("lbu_lit", data_o, 32'h00000080);
      run_op(LH, 32'h300, 0, 4'd3, 1, -1, 0);
      check("lh_lit", data_o, 32'hFFFF8001);
      run_op(LHU, 32'h300, 0, 4'd4, 0, -1, 0);
      check("lhu_lit", data_o, 32'h00008001);
      run_op(SH, 32'h10, 32'hDEADBEEF, 4'd6, 0, -1, 0);
      check("sh_b0", 32'(mem[16'h10]), 32'hEF);
      check("sh_b1", 32'(mem[16'h11]), 32'hBE);
      run_op(LW, 32'h400, 0, 4'd7, 0, 1, 0);
      check("rb_hold", data_o, 32'h00008001);

      // Load enable coinciding with rollback is dropped.
      @(posedge clk); #1;
      en = 1; rw = 0; op = 6'(LW); addr = 32'h100; roll = 1;
      @(posedge clk); #1;
      en = 0; roll = 0;
      repeat (3) @(posedge clk);
      #1;

      run_op(SB, 32'h30000, 32'h0000005A, 4'd8, 0, -1, 3);
      check("sb_io", 32'(mem[16'h0]), 32'h5A);
      run_op(SW, 32'h20, 32'h01020304, 4'd9, 1, 0, 0);
      check("sw_b3", 32'(mem[16'h23]), 32'h01);
      run_op(LW, 32'h20, 0, 4'd10, 0, -1, 0);
      check("sw_rd", data_o, 32'h01020304);

      // Reset in the middle of an SW transfer.
      chk_en = 0;
      @(posedge clk); #1;
      en = 1; rw = 1; op = 6'(SW); addr = 32'h40; wdata = 32'h99887766;
      @(posedge clk); #1;
      en = 0; grant = 1;
      @(posedge clk); #1;
      check("mr_wr0", mem_wr, 1);
      check("mr_a0", mem_a, 32'h40);
      @(posedge clk); #1;
      rst_n = 0; #1;
      check("mr_busy", busy, 0); check("mr_req", req, 0);
      check("mr_wr", mem_wr, 0); check("mr_a", mem_a, 0);
      check("mr_end", endp, 0);
      grant = 0;
      @(posedge clk); #1; rst_n = 1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("mr_noend", endp, 0);
         check("mr_idle", busy, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
